// File: rtl/fuzzifier_pkg.sv
// Shared types for the fuzzifier: membership word, FSM states, slope regions
// and the unity-membership constant helper.
package fuzzifier_pkg;

  localparam int MU_W_DEF = 16;

  typedef logic [MU_W_DEF-1:0] mu_t;

  typedef enum logic [1:0] {IDLE, CLASSIFY, DIVIDE, DONE} state_t;

  typedef enum logic [1:0] {FLAT0, FLAT1, RISE, FALL} region_t;

  function automatic logic [31:0] mu_one(input int mu_w);
    return 32'd1 << (mu_w - 1);
  endfunction

endpackage

// File: rtl/fuzz_slope_div.sv
// Serial restoring fractional divider: quo = floor(num * 2^(MU_W-1) / den), needs num < den.
// Latency MU_W-1 cycles after start; done and quo are valid during the final iteration cycle.
// No backpressure; a new start simply reloads the datapath.
module fuzz_slope_div #(
  parameter int X_W  = 8,
  parameter int MU_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [X_W:0]    num,
  input  logic [X_W:0]    den,
  output logic            done,
  output logic [MU_W-1:0] quo
);

  localparam int CNT_W = $clog2(MU_W);
  localparam int RW    = X_W + 1;

  logic [X_W:0]      rem;
  logic [X_W:0]      dn;
  logic [MU_W-2:0]   q;
  logic [CNT_W-1:0]  cnt;
  logic              run;

  logic [X_W+1:0]    rem_sh;
  logic              ge;
  logic [X_W:0]      rem_nx;
  logic [MU_W-1:0]   q_nx;

  // rem stays below den, so the shifted remainder always fits one extra bit
  always_comb begin
    rem_sh = {rem, 1'b0};
    ge     = (rem_sh >= {1'b0, dn});
    rem_nx = ge ? RW'(rem_sh - {1'b0, dn}) : rem_sh[X_W:0];
    q_nx   = {q, ge};
  end

  assign done = run && (cnt == CNT_W'(1));
  assign quo  = q_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      dn  <= '0;
      q   <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      rem <= num;
      dn  <= den;
      q   <= '0;
      cnt <= CNT_W'(MU_W - 1);
      run <= 1'b1;
    end else if (run) begin
      rem <= rem_nx;
      q   <= q_nx[MU_W-2:0];
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) run <= 1'b0;
    end
  end

endmodule

// File: rtl/fuzzifier_seq.sv
// Time-multiplexed trapezoidal fuzzifier; latency NUM_SETS+1 (all flat) to NUM_SETS*MU_W+1 (all slopes).
// in_ready only in IDLE; result held in DONE until out_ready. Optional FUZZ_CFG_CHECK_EN adds cfg_err.
module fuzzifier_seq
  import fuzzifier_pkg::*;
#(
  parameter int NUM_SETS = 5,
  parameter int X_W      = 8,
  parameter int MU_W     = 16,
  localparam int IDX_W   = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [IDX_W-1:0]         cfg_set,
  input  logic [X_W-1:0]           cfg_a,
  input  logic [X_W-1:0]           cfg_b,
  input  logic [X_W-1:0]           cfg_c,
  input  logic [X_W-1:0]           cfg_d,
  output logic                     cfg_ready,
  input  logic                     in_valid,
  input  logic [X_W-1:0]           in_x,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_SETS*MU_W-1:0] out_mu,
  output logic                     busy
`ifdef FUZZ_CFG_CHECK_EN
  ,
  output logic [NUM_SETS-1:0]      cfg_err
`endif
);

  localparam logic [MU_W-1:0]  MU_ONE = MU_W'(mu_one(MU_W));
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_SETS - 1);

  state_t             state;
  logic [X_W-1:0]     x_r;
  logic [IDX_W-1:0]   idx;
  logic [X_W-1:0]     bp_a [NUM_SETS];
  logic [X_W-1:0]     bp_b [NUM_SETS];
  logic [X_W-1:0]     bp_c [NUM_SETS];
  logic [X_W-1:0]     bp_d [NUM_SETS];
  logic [MU_W-1:0]    work [NUM_SETS];

  logic signed [X_W:0] xs, sa, sb, sc, sd;
  region_t             region;
  logic [X_W:0]        num, den;
  logic                div_start, div_done, last;
  logic [MU_W-1:0]     div_q;

  assign in_ready  = (state == IDLE);
  assign cfg_ready = (state == IDLE);
  assign busy      = (state == CLASSIFY) || (state == DIVIDE) || ((state == DONE) && !out_valid);
  assign last      = (idx == LAST);

  // Priority order guarantees den > 0 whenever a slope is selected
  always_comb begin
    xs     = {x_r[X_W-1], x_r};
    sa     = {bp_a[idx][X_W-1], bp_a[idx]};
    sb     = {bp_b[idx][X_W-1], bp_b[idx]};
    sc     = {bp_c[idx][X_W-1], bp_c[idx]};
    sd     = {bp_d[idx][X_W-1], bp_d[idx]};
    region = FLAT0;
    num    = '0;
    den    = '0;
    if (xs >= sb && xs <= sc) begin
      region = FLAT1;
    end else if (xs <= sa || xs >= sd) begin
      region = FLAT0;
    end else if (xs < sb) begin
      region = RISE;
      num    = xs - sa;
      den    = sb - sa;
    end else begin
      region = FALL;
      num    = sd - xs;
      den    = sd - sc;
    end
`ifdef FUZZ_CFG_CHECK_EN
    if (cfg_err[idx]) begin
      region = FLAT0;
      num    = '0;
      den    = '0;
    end
`endif
  end

  assign div_start = (state == CLASSIFY) && ((region == RISE) || (region == FALL));

  fuzz_slope_div #(
    .X_W  (X_W),
    .MU_W (MU_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (num),
    .den   (den),
    .done  (div_done),
    .quo   (div_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_r       <= '0;
      idx       <= '0;
      out_mu    <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NUM_SETS; i++) begin
        bp_a[i] <= '0;
        bp_b[i] <= '0;
        bp_c[i] <= '0;
        bp_d[i] <= '0;
        work[i] <= '0;
      end
`ifdef FUZZ_CFG_CHECK_EN
      cfg_err <= '0;
`endif
    end else begin
      if (cfg_we && (state == IDLE) && (cfg_set <= LAST)) begin
        bp_a[cfg_set] <= cfg_a;
        bp_b[cfg_set] <= cfg_b;
        bp_c[cfg_set] <= cfg_c;
        bp_d[cfg_set] <= cfg_d;
`ifdef FUZZ_CFG_CHECK_EN
        cfg_err[cfg_set] <= !(($signed(cfg_a) <= $signed(cfg_b)) &&
                              ($signed(cfg_b) <= $signed(cfg_c)) &&
                              ($signed(cfg_c) <= $signed(cfg_d)));
`endif
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r   <= in_x;
            idx   <= '0;
            state <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          if (div_start) begin
            state <= DIVIDE;
          end else begin
            work[idx] <= (region == FLAT1) ? MU_ONE : '0;
            idx       <= idx + IDX_W'(1);
            state     <= last ? DONE : CLASSIFY;
          end
        end
        DIVIDE: begin
          if (div_done) begin
            work[idx] <= div_q;
            idx       <= idx + IDX_W'(1);
            state     <= last ? DONE : CLASSIFY;
          end
        end
        DONE: begin
          // First DONE cycle publishes the vector; it then holds until taken
          if (!out_valid) begin
            out_valid <= 1'b1;
            for (int i = 0; i < NUM_SETS; i++) out_mu[i*MU_W +: MU_W] <= work[i];
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzzifier_seq.sv
// Randomized self-checking bench for fuzzifier_seq against an arithmetic membership model.
module tb_fuzzifier_seq;
  import fuzzifier_pkg::*;

  localparam int NS  = 5;
  localparam int XW  = 8;
  localparam int MUW = 16;
  localparam int IW  = 3;
  localparam int ONE = 1 << (MUW - 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_we;
  logic [IW-1:0]   cfg_set;
  logic [XW-1:0]   cfg_a, cfg_b, cfg_c, cfg_d;
  logic            cfg_ready;
  logic            in_valid;
  logic [XW-1:0]   in_x;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [NS*MUW-1:0] out_mu;
  logic            busy;
`ifdef FUZZ_CFG_CHECK_EN
  logic [NS-1:0]   cfg_err;
`endif

  always #5 clk = ~clk;

  fuzzifier_seq #(.NUM_SETS(NS), .X_W(XW), .MU_W(MUW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_set   (cfg_set),
    .cfg_a     (cfg_a),
    .cfg_b     (cfg_b),
    .cfg_c     (cfg_c),
    .cfg_d     (cfg_d),
    .cfg_ready (cfg_ready),
    .in_valid  (in_valid),
    .in_x      (in_x),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mu    (out_mu),
    .busy      (busy)
`ifdef FUZZ_CFG_CHECK_EN
    ,
    .cfg_err   (cfg_err)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  int ma [NS];
  int mb [NS];
  int mc [NS];
  int md [NS];
  bit mbad [NS];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int ref_mu(input int s, input int x);
    if (mbad[s]) return 0;
    if (x >= mb[s] && x <= mc[s]) return ONE;
    if (x <= ma[s] || x >= md[s]) return 0;
    if (x < mb[s]) return ((x - ma[s]) * ONE) / (mb[s] - ma[s]);
    return ((md[s] - x) * ONE) / (md[s] - mc[s]);
  endfunction

  function automatic logic [NS*MUW-1:0] exp_vec(input int x);
    logic [NS*MUW-1:0] v;
    v = '0;
    for (int s = 0; s < NS; s++) v[s*MUW +: MUW] = MUW'(ref_mu(s, x));
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      ma[s] = 0; mb[s] = 0; mc[s] = 0; md[s] = 0; mbad[s] = 1'b0;
    end
  endtask

  task automatic model_write(input int s, input int a, input int b, input int c, input int d);
    if (s < NS) begin
      ma[s] = a; mb[s] = b; mc[s] = c; md[s] = d;
`ifdef FUZZ_CFG_CHECK_EN
      mbad[s] = !(a <= b && b <= c && c <= d);
`endif
    end
  endtask

  task automatic drive_cfg(input int s, input int a, input int b, input int c, input int d);
    cfg_set = IW'(s);
    cfg_a = a[XW-1:0];
    cfg_b = b[XW-1:0];
    cfg_c = c[XW-1:0];
    cfg_d = d[XW-1:0];
  endtask

  task automatic cfg_write(input int s, input int a, input int b, input int c, input int d);
    @(negedge clk);
    cfg_we = 1'b1;
    drive_cfg(s, a, b, c, d);
    chk("cfg_ready_idle", cfg_ready, 1);
    @(posedge clk);
    #1 cfg_we = 1'b0;
    model_write(s, a, b, c, d);
  endtask

  task automatic send(input int x);
    @(negedge clk);
    chk("in_ready_send", in_ready, 1);
    in_valid = 1'b1;
    in_x = x[XW-1:0];
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(input int x, input int exp_lat, input int hold);
    int lat;
    logic [NS*MUW-1:0] ev;
    lat = 0;
    ev = exp_vec(x);
    while (!out_valid && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (exp_lat > 0) chk("latency", lat, exp_lat);
    else chk("latency_range", (lat >= NS + 1 && lat <= NS * MUW + 1), 1);
    chk("out_valid", out_valid, 1);
    chk("busy_done", busy, 0);
    chk("in_ready_done", in_ready, 0);
    for (int s = 0; s < NS; s++)
      chk($sformatf("mu%0d x=%0d", s, x), out_mu[s*MUW +: MUW], ev[s*MUW +: MUW]);
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        @(negedge clk);
        cfg_we = 1'b1;
        drive_cfg(0, 1, 2, 3, 4);
        chk("cfg_ready_done", cfg_ready, 0);
        @(posedge clk);
        #1 cfg_we = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      chk("hold_valid", out_valid, 1);
      chk("hold_mu", out_mu, ev);
      chk("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("in_ready_idle", in_ready, 1);
  endtask

  initial begin
    int v [4];
    int t, viol, xr;
    rst_n = 1'b0;
    cfg_we = 1'b0;
    cfg_set = '0;
    cfg_a = '0; cfg_b = '0; cfg_c = '0; cfg_d = '0;
    in_valid = 1'b0;
    in_x = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_mu", out_mu, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cfg_ready", cfg_ready, 1);

    send(0);
    collect(0, NS + 1, 0);

    cfg_write(0, -64, 0, 0, 64);
    send(-32); collect(-32, 0, 0);
    send(32);  collect(32, 0, 0);
    send(0);   collect(0, 0, 0);
    send(64);  collect(64, 0, 0);

    cfg_write(1, -128, -128, -64, 0);
    send(-128); collect(-128, 0, 0);
    send(-32);  collect(-32, 0, 0);

    // Held output plus an attempted write that must be dropped
    send(-32);
    collect(-32, 0, 20);
    send(-48); collect(-48, 0, 0);

    // Write and sample in the same cycle: the new set must apply
    @(negedge clk);
    cfg_we = 1'b1;
    drive_cfg(3, -100, -20, 10, 90);
    in_valid = 1'b1;
    in_x = 8'hC4;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    in_valid = 1'b0;
    model_write(3, -100, -20, 10, 90);
    collect(-60, 0, 0);

    cfg_write(7, 1, 2, 3, 4);
    send(2); collect(2, 0, 0);

    for (int s = 0; s < NS; s++) cfg_write(s, -64, 0, 0, 64);
    send(-32);
    collect(-32, NS * MUW + 1, 0);

`ifdef FUZZ_CFG_CHECK_EN
    cfg_write(2, 10, 5, 20, 30);
    #1 chk("cfg_err_set", cfg_err[2], 1);
    send(15); collect(15, 0, 0);
    send(25); collect(25, 0, 0);
    cfg_write(2, 10, 15, 20, 30);
    #1 chk("cfg_err_clr", cfg_err[2], 0);
    send(12); collect(12, 0, 0);
`endif

    for (int it = 0; it < 25; it++) begin
      repeat (2) begin
        for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(0, 255)) - 128;
        if ($urandom_range(0, 3) != 0) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
              if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        end
        cfg_write(int'($urandom_range(0, 7)), v[0], v[1], v[2], v[3]);
      end
      xr = int'($urandom_range(0, 255)) - 128;
      send(xr);
      collect(xr, 0, int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a division
    for (int s = 0; s < NS; s++) cfg_write(s, -64, 0, 0, 64);
    send(-32);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_mu", out_mu, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) viol++;
    end
    chk("midrst_no_valid", viol, 0);
    send(-32);
    collect(-32, NS + 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
